// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I-subset core: fetch over a ready/valid
// handshake, decode, and sequence ALU, data memory, register file and PC update.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        IMemReq,
  input  logic        IMemValid,
  input  logic [31:0] IMemRdata,
  output logic        DMemReq,
  output logic        DMemWe,
  input  logic        DMemValid,
  input  logic        Zero,
  output logic [24:0] Instr31_7,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [2:0]  ALUCtrl,
  output logic [1:0]  ResultSrc,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        Trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t      state_q;
  logic [31:0] ir_q;
  logic [15:0] cnt_q;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic        reg_write_q;
  logic        pc_write_q;
  logic [1:0]  pc_src_q;
  logic [1:0]  result_src_q;
  logic        trap_q;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        is_branch_s;
  logic        is_bne_s;
  logic        is_jal_s;
  logic        is_jalr_s;
  logic        legal_s;
  logic [1:0]  imm_src_s;
  logic        alu_src_s;
  logic [2:0]  alu_ctrl_s;
  logic        taken_s;
  logic        branch_exec_s;
  logic        store_done_s;

  assign opcode_s = ir_q[6:0];
  assign funct3_s = ir_q[14:12];
  assign funct7_s = ir_q[31:25];

  // Instruction classification and datapath controls, held stable by the frozen IR
  always_comb begin
    is_load_s   = 1'b0;
    is_store_s  = 1'b0;
    is_branch_s = 1'b0;
    is_bne_s    = 1'b0;
    is_jal_s    = 1'b0;
    is_jalr_s   = 1'b0;
    legal_s     = 1'b0;
    imm_src_s   = IMM_I;
    alu_src_s   = 1'b0;
    alu_ctrl_s  = ALU_ADD;
    case (opcode_s)
      OP_LOAD: begin
        is_load_s = 1'b1;
        legal_s   = 1'b1;
        alu_src_s = 1'b1;
      end
      OP_STORE: begin
        is_store_s = 1'b1;
        legal_s    = 1'b1;
        imm_src_s  = IMM_S;
        alu_src_s  = 1'b1;
      end
      OP_R: begin
        case (funct3_s)
          3'b000: begin
            if (funct7_s == F7_BASE) begin
              legal_s = 1'b1;
            end else if (funct7_s == F7_ALT) begin
              legal_s    = 1'b1;
              alu_ctrl_s = ALU_SUB;
            end else begin
              legal_s = 1'b0;
            end
          end
          3'b111: begin
            legal_s    = (funct7_s == F7_BASE);
            alu_ctrl_s = ALU_AND;
          end
          3'b110: begin
            legal_s    = (funct7_s == F7_BASE);
            alu_ctrl_s = ALU_OR;
          end
          3'b010: begin
            legal_s    = (funct7_s == F7_BASE);
            alu_ctrl_s = ALU_SLT;
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_IALU: begin
        alu_src_s = 1'b1;
        case (funct3_s)
          3'b000:  legal_s = 1'b1;
          3'b111: begin
            legal_s    = 1'b1;
            alu_ctrl_s = ALU_AND;
          end
          3'b110: begin
            legal_s    = 1'b1;
            alu_ctrl_s = ALU_OR;
          end
          3'b010: begin
            legal_s    = 1'b1;
            alu_ctrl_s = ALU_SLT;
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        is_branch_s = 1'b1;
        imm_src_s   = IMM_B;
        alu_ctrl_s  = ALU_SUB;
        case (funct3_s)
          3'b000:  legal_s = 1'b1;
          3'b001: begin
            legal_s  = 1'b1;
            is_bne_s = 1'b1;
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_JAL: begin
        is_jal_s  = 1'b1;
        legal_s   = 1'b1;
        imm_src_s = IMM_J;
      end
      OP_JALR: begin
        is_jalr_s = 1'b1;
        legal_s   = 1'b1;
        alu_src_s = 1'b1;
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Zero and DMemValid only settle within the cycle that consumes them
  always_comb begin
    taken_s       = is_bne_s ? ~Zero : Zero;
    branch_exec_s = rst_n & (state_q == S_EXEC) & is_branch_s;
    store_done_s  = rst_n & (state_q == S_MEM) & is_store_s & DMemValid;
  end

  // Main sequencer; strobes default low so each is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      ir_q         <= 32'd0;
      cnt_q        <= 16'd0;
      imem_req_q   <= 1'b1;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_write_q   <= 1'b0;
      pc_src_q     <= PC_PLUS4;
      result_src_q <= RES_ALU;
      trap_q       <= 1'b0;
    end else begin
      reg_write_q  <= 1'b0;
      pc_write_q   <= 1'b0;
      pc_src_q     <= PC_PLUS4;
      result_src_q <= RES_ALU;
      case (state_q)
        S_FETCH: begin
          if (IMemValid) begin
            ir_q       <= IMemRdata;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end else if (cnt_q == TIMEOUT_C) begin
            imem_req_q <= 1'b0;
            trap_q     <= 1'b1;
            state_q    <= S_TRAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DECODE: begin
          if (!legal_s) begin
            trap_q  <= 1'b1;
            state_q <= S_TRAP;
          end else begin
            pc_write_q <= is_branch_s;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_load_s || is_store_s) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_store_s;
            cnt_q      <= 16'd0;
            state_q    <= S_MEM;
          end else if (is_branch_s) begin
            imem_req_q <= 1'b1;
            cnt_q      <= 16'd0;
            state_q    <= S_FETCH;
          end else begin
            reg_write_q  <= 1'b1;
            pc_write_q   <= 1'b1;
            result_src_q <= (is_jal_s || is_jalr_s) ? RES_PC4 : RES_ALU;
            pc_src_q     <= is_jal_s ? PC_IMM : (is_jalr_s ? PC_ALU : PC_PLUS4);
            state_q      <= S_WB;
          end
        end
        S_MEM: begin
          if (DMemValid) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (is_store_s) begin
              imem_req_q <= 1'b1;
              cnt_q      <= 16'd0;
              state_q    <= S_FETCH;
            end else begin
              reg_write_q  <= 1'b1;
              pc_write_q   <= 1'b1;
              result_src_q <= RES_LOAD;
              state_q      <= S_WB;
            end
          end else if (cnt_q == TIMEOUT_C) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            trap_q     <= 1'b1;
            state_q    <= S_TRAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_WB: begin
          imem_req_q <= 1'b1;
          cnt_q      <= 16'd0;
          state_q    <= S_FETCH;
        end
        S_TRAP: begin
          imem_req_q <= 1'b0;
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          trap_q     <= 1'b1;
          state_q    <= S_TRAP;
        end
        default: begin
          imem_req_q <= 1'b0;
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          trap_q     <= 1'b1;
          state_q    <= S_TRAP;
        end
      endcase
    end
  end

  assign IMemReq   = imem_req_q;
  assign DMemReq   = dmem_req_q;
  assign DMemWe    = dmem_we_q;
  assign Instr31_7 = ir_q[31:7];
  assign ImmSrc    = imm_src_s;
  assign ALUSrc    = alu_src_s;
  assign ALUCtrl   = alu_ctrl_s;
  assign ResultSrc = result_src_q;
  assign RegWrite  = rst_n & reg_write_q;
  assign PCWrite   = (rst_n & pc_write_q) | store_done_s;
  assign PCSrc     = branch_exec_s ? {1'b0, taken_s} : pc_src_q;
  assign Trap      = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle, plus illegal-opcode, fetch-timeout and mid-access reset cases.
module tb_multicycle_ctrl;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SW   = 32'h00112223;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] JAL  = 32'h008000EF;
  localparam logic [31:0] JALR = 32'h000080E7;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] LW   = 32'h0040A103;
  localparam logic [31:0] LUI  = 32'h00000037;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IMemReq;
  logic        IMemValid;
  logic [31:0] IMemRdata;
  logic        DMemReq;
  logic        DMemWe;
  logic        DMemValid;
  logic        Zero;
  logic [24:0] Instr31_7;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [2:0]  ALUCtrl;
  logic [1:0]  ResultSrc;
  logic        RegWrite;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        Trap;

  int total = 0;
  int bad = 0;
  int pcw_cnt = 0;
  int rw_cnt = 0;
  int pcw0;
  int rw0;

  multicycle_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .IMemReq(IMemReq), .IMemValid(IMemValid), .IMemRdata(IMemRdata),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemValid(DMemValid),
    .Zero(Zero), .Instr31_7(Instr31_7), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
    .ALUCtrl(ALUCtrl), .ResultSrc(ResultSrc), .RegWrite(RegWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .Trap(Trap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (PCWrite) pcw_cnt <= pcw_cnt + 1;
    if (RegWrite) rw_cnt <= rw_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Present an instruction in the current FETCH cycle and advance into DECODE
  task automatic run_fetch(input logic [31:0] ins);
    IMemValid = 1'b1;
    IMemRdata = ins;
    #1;
    chk("fetch.req", {31'd0, IMemReq}, 32'd1);
    step;
    IMemValid = 1'b0;
    IMemRdata = 32'hFFFF_FFFF;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; IMemValid = 1'b0; IMemRdata = 32'd0;
    DMemValid = 1'b0; Zero = 1'b0;
    step; step;
    chk("rst.imemreq", {31'd0, IMemReq}, 32'd1);
    chk("rst.dmemreq", {31'd0, DMemReq}, 32'd0);
    chk("rst.strobes", {30'd0, RegWrite, PCWrite}, 32'd0);
    chk("rst.trap", {31'd0, Trap}, 32'd0);
    chk("rst.instr", {7'd0, Instr31_7}, 32'd0);
    chk("rst.ctrl", {25'd0, ImmSrc, ALUSrc, ALUCtrl, 1'b0}, 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,5
    pcw0 = pcw_cnt; rw0 = rw_cnt;
    run_fetch(ADDI);
    chk("addi.dec.immsrc", {30'd0, ImmSrc}, 32'd0);
    chk("addi.dec.alusrc", {31'd0, ALUSrc}, 32'd1);
    chk("addi.dec.aluctrl", {29'd0, ALUCtrl}, 32'd0);
    chk("addi.dec.instr", {7'd0, Instr31_7}, 32'h00A001);
    chk("addi.dec.imemreq", {31'd0, IMemReq}, 32'd0);
    step;
    chk("addi.exec.strobes", {30'd0, RegWrite, PCWrite}, 32'd0);
    step;
    chk("addi.wb.strobes", {30'd0, RegWrite, PCWrite}, 32'd3);
    chk("addi.wb.pcsrc", {30'd0, PCSrc}, 32'd0);
    chk("addi.wb.ressrc", {30'd0, ResultSrc}, 32'd0);
    step;
    chk("addi.fetch.imemreq", {31'd0, IMemReq}, 32'd1);
    chk("addi.fetch.strobes", {30'd0, RegWrite, PCWrite}, 32'd0);
    chk("addi.pcw_count", pcw_cnt - pcw0, 32'd1);
    chk("addi.rw_count", rw_cnt - rw0, 32'd1);

    // sw with DMemValid three cycles late
    pcw0 = pcw_cnt; rw0 = rw_cnt;
    run_fetch(SW);
    chk("sw.dec.immsrc", {30'd0, ImmSrc}, 32'd1);
    chk("sw.dec.alusrc", {31'd0, ALUSrc}, 32'd1);
    step;
    chk("sw.exec.dmemreq", {31'd0, DMemReq}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("sw.memwait.req_we", {30'd0, DMemReq, DMemWe}, 32'd3);
      chk("sw.memwait.pcwrite", {31'd0, PCWrite}, 32'd0);
    end
    step;
    DMemValid = 1'b1;
    #1;
    chk("sw.memdone.req_we", {30'd0, DMemReq, DMemWe}, 32'd3);
    chk("sw.memdone.strobes", {30'd0, RegWrite, PCWrite}, 32'd1);
    chk("sw.memdone.pcsrc", {30'd0, PCSrc}, 32'd0);
    step;
    DMemValid = 1'b0;
    chk("sw.fetch.dmemreq", {31'd0, DMemReq}, 32'd0);
    chk("sw.fetch.imemreq", {31'd0, IMemReq}, 32'd1);
    chk("sw.pcw_count", pcw_cnt - pcw0, 32'd1);
    chk("sw.rw_count", rw_cnt - rw0, 32'd0);

    // beq taken
    run_fetch(BEQ);
    chk("beq.dec.immsrc", {30'd0, ImmSrc}, 32'd2);
    chk("beq.dec.alusrc", {31'd0, ALUSrc}, 32'd0);
    chk("beq.dec.aluctrl", {29'd0, ALUCtrl}, 32'd1);
    step;
    Zero = 1'b1;
    #1;
    chk("beq1.exec.strobes", {30'd0, RegWrite, PCWrite}, 32'd1);
    chk("beq1.exec.pcsrc", {30'd0, PCSrc}, 32'd1);
    step;
    Zero = 1'b0;
    chk("beq1.fetch.imemreq", {31'd0, IMemReq}, 32'd1);
    chk("beq1.fetch.pcwrite", {31'd0, PCWrite}, 32'd0);

    // beq not taken
    run_fetch(BEQ);
    step;
    Zero = 1'b0;
    #1;
    chk("beq0.exec.pcwrite", {31'd0, PCWrite}, 32'd1);
    chk("beq0.exec.pcsrc", {30'd0, PCSrc}, 32'd0);
    step;
    chk("beq0.fetch.imemreq", {31'd0, IMemReq}, 32'd1);

    // bne taken on Zero=0
    run_fetch(BNE);
    step;
    #1;
    chk("bne.exec.pcsrc", {30'd0, PCSrc}, 32'd1);
    step;

    // jal
    run_fetch(JAL);
    chk("jal.dec.immsrc", {30'd0, ImmSrc}, 32'd3);
    step; step;
    chk("jal.wb.strobes", {30'd0, RegWrite, PCWrite}, 32'd3);
    chk("jal.wb.ressrc", {30'd0, ResultSrc}, 32'd2);
    chk("jal.wb.pcsrc", {30'd0, PCSrc}, 32'd1);
    step;

    // jalr
    run_fetch(JALR);
    chk("jalr.dec.ctrl", {26'd0, ImmSrc, ALUSrc, ALUCtrl}, 32'h08);
    step; step;
    chk("jalr.wb.ressrc", {30'd0, ResultSrc}, 32'd2);
    chk("jalr.wb.pcsrc", {30'd0, PCSrc}, 32'd2);
    step;

    // sub
    run_fetch(SUB);
    chk("sub.dec.ctrl", {26'd0, ImmSrc, ALUSrc, ALUCtrl}, 32'h01);
    step; step;
    chk("sub.wb.strobes", {30'd0, RegWrite, PCWrite}, 32'd3);
    chk("sub.wb.ressrc", {30'd0, ResultSrc}, 32'd0);
    step;

    // lw zero-wait: five cycles
    run_fetch(LW);
    chk("lw.dec.ctrl", {26'd0, ImmSrc, ALUSrc, ALUCtrl}, 32'h08);
    step; step;
    DMemValid = 1'b1;
    #1;
    chk("lw.mem.req_we", {30'd0, DMemReq, DMemWe}, 32'd2);
    chk("lw.mem.pcwrite", {31'd0, PCWrite}, 32'd0);
    step;
    DMemValid = 1'b0;
    chk("lw.wb.strobes", {30'd0, RegWrite, PCWrite}, 32'd3);
    chk("lw.wb.ressrc", {30'd0, ResultSrc}, 32'd1);
    chk("lw.wb.pcsrc", {30'd0, PCSrc}, 32'd0);
    step;
    chk("lw.fetch.imemreq", {31'd0, IMemReq}, 32'd1);

    // fetch valid in the very cycle the counter reaches TIMEOUT still wins
    repeat (8) step;
    chk("tmo_edge.trap", {31'd0, Trap}, 32'd0);
    chk("tmo_edge.imemreq", {31'd0, IMemReq}, 32'd1);
    run_fetch(ADDI);
    chk("tmo_edge.dec.trap", {31'd0, Trap}, 32'd0);
    chk("tmo_edge.dec.instr", {7'd0, Instr31_7}, 32'h00A001);
    step; step; step;

    // illegal opcode traps and stays trapped
    pcw0 = pcw_cnt; rw0 = rw_cnt;
    run_fetch(LUI);
    chk("lui.dec.trap", {31'd0, Trap}, 32'd0);
    step;
    chk("lui.trap", {31'd0, Trap}, 32'd1);
    chk("lui.trap.reqs", {30'd0, IMemReq, DMemReq}, 32'd0);
    IMemValid = 1'b1; IMemRdata = ADDI; DMemValid = 1'b1;
    repeat (3) step;
    chk("lui.sticky.trap", {31'd0, Trap}, 32'd1);
    chk("lui.sticky.imemreq", {31'd0, IMemReq}, 32'd0);
    chk("lui.sticky.ir", {7'd0, Instr31_7}, 32'd0);
    chk("lui.pcw_count", pcw_cnt - pcw0, 32'd0);
    chk("lui.rw_count", rw_cnt - rw0, 32'd0);
    IMemValid = 1'b0; DMemValid = 1'b0;
    rst_n = 1'b0;
    step;
    chk("lui.reset.trap", {31'd0, Trap}, 32'd0);
    chk("lui.reset.imemreq", {31'd0, IMemReq}, 32'd1);
    rst_n = 1'b1;

    // fetch timeout
    repeat (8) step;
    chk("tmo.wait.trap", {31'd0, Trap}, 32'd0);
    step;
    chk("tmo.trap", {31'd0, Trap}, 32'd1);
    chk("tmo.imemreq", {31'd0, IMemReq}, 32'd0);
    repeat (2) step;
    chk("tmo.sticky", {31'd0, Trap}, 32'd1);
    rst_n = 1'b0;
    step;
    chk("tmo.reset.trap", {31'd0, Trap}, 32'd0);
    rst_n = 1'b1;

    // reset in the middle of a load's MEM phase
    run_fetch(LW);
    step; step;
    chk("lwrst.mem.dmemreq", {31'd0, DMemReq}, 32'd1);
    pcw0 = pcw_cnt; rw0 = rw_cnt;
    rst_n = 1'b0; DMemValid = 1'b1;
    #1;
    chk("lwrst.mem.strobes", {30'd0, RegWrite, PCWrite}, 32'd0);
    step;
    DMemValid = 1'b0;
    chk("lwrst.fetch.dmemreq", {31'd0, DMemReq}, 32'd0);
    chk("lwrst.fetch.imemreq", {31'd0, IMemReq}, 32'd1);
    rst_n = 1'b1;
    step;
    chk("lwrst.after.strobes", {30'd0, RegWrite, PCWrite}, 32'd0);
    chk("lwrst.pcw_count", pcw_cnt - pcw0, 32'd0);
    chk("lwrst.rw_count", rw_cnt - rw0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
